// File: rtl/tff_mod_counter_pkg.sv
// Shared constants and next-value helpers for the toggle-flop modulo counter.
// Values are carried as 32-bit unsigned so one definition serves every WIDTH.
package tff_mod_counter_pkg;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

    // Out-of-range states (only reachable when MODULUS < 2**WIDTH) recover to 0.
    function automatic int unsigned next_count(input int unsigned q,
                                               input logic        up_dn,
                                               input int unsigned modulus);
        int unsigned r;
        if (q >= modulus)
            r = 0;
        else if (up_dn == DIR_UP)
            r = (q == modulus - 1) ? 0 : q + 1;
        else
            r = (q == 0) ? modulus - 1 : q - 1;
        return r;
    endfunction

    function automatic int unsigned clamp_load(input int unsigned load_val,
                                               input int unsigned modulus);
        return (load_val >= modulus) ? modulus - 1 : load_val;
    endfunction

endpackage

// File: rtl/tff_mod_counter_cell.sv
// Single toggle flip-flop with synchronous active-high reset.
module tff_cell_sync (
    input  logic clk,
    input  logic rst,
    input  logic t,
    output logic q
);

    always_ff @(posedge clk) begin
        if (rst)
            q <= 1'b0;
        else
            q <= q ^ t;
    end

endmodule

// File: rtl/tff_mod_counter.sv
// Up/down modulo-N counter: a shared next-state generator drives a chain of
// T cells through t = q ^ q_next; adds terminal count and a sticky wrap flag.
module tff_mod_counter
    import tff_mod_counter_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] MOD_LAST = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] t;

    // Reset is not folded in here; each cell clears itself on rst.
    always_comb begin
        q_next = q;
        if (load)
            q_next = WIDTH'(clamp_load(32'(load_val), MODULUS));
        else if (en)
            q_next = WIDTH'(next_count(32'(q), up_dn, MODULUS));
    end

    assign t  = q ^ q_next;

    assign tc = en & ~load &
                (((up_dn == DIR_UP) & (q == MOD_LAST)) |
                 ((up_dn == DIR_DN) & (q == '0)));

    always_ff @(posedge clk) begin
        if (rst)
            wrap <= 1'b0;
        else if (load)
            wrap <= 1'b0;
        else if (tc)
            wrap <= 1'b1;
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        tff_cell_sync u_cell (
            .clk (clk),
            .rst (rst),
            .t   (t[i]),
            .q   (q[i])
        );
    end

endmodule

// File: tb/tb_tff_mod_counter.sv
// Directed scoreboard bench: a MODULUS=10 counter and a full-range 3-bit counter.
module tb_tff_mod_counter;

    typedef struct {
        int    q;
        logic  w;
        string tag;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b0, en = 1'b0, up_dn = 1'b0, load = 1'b0;
    logic [3:0] load_val = '0;
    logic [3:0] q;
    logic       tc, wrap;

    logic       rst8 = 1'b0, en8 = 1'b0;
    logic [2:0] q8;
    logic       tc8, wrap8;

    tff_mod_counter #(.WIDTH(4), .MODULUS(10)) dut (
        .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load),
        .load_val(load_val), .q(q), .tc(tc), .wrap(wrap)
    );

    tff_mod_counter #(.WIDTH(3), .MODULUS(8)) dut8 (
        .clk(clk), .rst(rst8), .en(en8), .up_dn(1'b1), .load(1'b0),
        .load_val(3'd0), .q(q8), .tc(tc8), .wrap(wrap8)
    );

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   mq = 0, mq8 = 0;
    logic mwrap = 1'b0, mwrap8 = 1'b0;
    logic known = 1'b0, known8 = 1'b0;

    task automatic step(input logic r, input logic l, input logic [3:0] lv,
                        input logic e, input logic u, input string tag);
        exp_t ex;
        logic etc;
        int   nq;
        logic nw;
        rst = r; load = l; load_val = lv; en = e; up_dn = u;
        #1;
        etc = e & ~l & ((u & (mq == 9)) | (~u & (mq == 0)));
        if (known) begin
            checks++;
            assert (tc === etc) else begin
                errors++;
                $error("FAIL %s tc: got %b want %b", tag, tc, etc);
            end
        end
        if (r) begin
            nq = 0; nw = 1'b0;
        end else if (l) begin
            nq = (lv > 4'd9) ? 9 : int'(lv); nw = 1'b0;
        end else if (e) begin
            nq = u ? (mq + 1) % 10 : (mq + 9) % 10; nw = mwrap | etc;
        end else begin
            nq = mq; nw = mwrap;
        end
        sb.push_back('{q: nq, w: nw, tag: tag});
        @(posedge clk); #1;
        ex = sb.pop_front();
        mq = ex.q; mwrap = ex.w;
        if (r) known = 1'b1;
        checks++;
        assert (q === 4'(ex.q)) else begin
            errors++;
            $error("FAIL %s q: got %0d want %0d", ex.tag, q, ex.q);
        end
        checks++;
        assert (wrap === ex.w) else begin
            errors++;
            $error("FAIL %s wrap: got %b want %b", ex.tag, wrap, ex.w);
        end
    endtask

    task automatic step8(input logic r, input logic e, input string tag);
        exp_t ex;
        logic etc;
        int   nq;
        rst8 = r; en8 = e;
        #1;
        etc = e & (mq8 == 7);
        nq  = e ? (mq8 + 1) % 8 : mq8;
        if (known8) begin
            checks++;
            assert (tc8 === etc) else begin
                errors++;
                $error("FAIL %s tc8: got %b want %b", tag, tc8, etc);
            end
            if (!r) begin
                checks++;
                assert (dut8.t === 3'(mq8 ^ nq)) else begin
                    errors++;
                    $error("FAIL %s t8: got %b want %b", tag, dut8.t, 3'(mq8 ^ nq));
                end
            end
        end
        if (r) nq = 0;
        sb.push_back('{q: nq, w: r ? 1'b0 : (mwrap8 | etc), tag: tag});
        @(posedge clk); #1;
        ex = sb.pop_front();
        mq8 = ex.q; mwrap8 = ex.w;
        if (r) known8 = 1'b1;
        checks++;
        assert (q8 === 3'(ex.q)) else begin
            errors++;
            $error("FAIL %s q8: got %0d want %0d", ex.tag, q8, ex.q);
        end
        checks++;
        assert (wrap8 === ex.w) else begin
            errors++;
            $error("FAIL %s wrap8: got %b want %b", ex.tag, wrap8, ex.w);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset held two cycles with competing load/en.
        step(1'b1, 1'b1, 4'd7, 1'b1, 1'b1, "rst1");
        step(1'b1, 1'b1, 4'd7, 1'b1, 1'b1, "rst2");
        // Up through the 9->0 wrap and beyond.
        for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 4'd0, 1'b1, 1'b1, "up");
        // Down wrap from 2.
        step(1'b0, 1'b1, 4'd2, 1'b0, 1'b0, "ld2");
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, "down");
        step(1'b0, 1'b0, 4'd0, 1'b1, 1'b1, "up_to9");
        // Load beats a pending wrap; 12 clamps to 9.
        step(1'b0, 1'b1, 4'd12, 1'b1, 1'b1, "ld_clamp");
        step(1'b0, 1'b1, 4'd3, 1'b1, 1'b0, "ld3");
        step(1'b0, 1'b0, 4'd0, 1'b1, 1'b1, "up4");
        step(1'b0, 1'b0, 4'd0, 1'b1, 1'b1, "up5");
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 4'd0, 1'b0, 1'b1, "hold");
        for (int i = 0; i < 4; i++)
            step(1'b0, 1'b0, 4'd0, 1'b1, (i % 2 == 0), "flip");
        step(1'b0, 1'b1, 4'd15, 1'b0, 1'b0, "ld15");
        step(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, "dn_from9");
        step(1'b1, 1'b1, 4'd5, 1'b1, 1'b1, "rst_mid");
        step(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, "dn_from0");
        // Full-range 3-bit counter, natural 7->0 wrap.
        step8(1'b1, 1'b1, "rst8");
        for (int i = 0; i < 10; i++) step8(1'b0, 1'b1, "up8");
        step8(1'b0, 1'b0, "hold8");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
